frame_peak_rms: RTL

Per-frame peak and energy accumulator. It sits directly downstream of `skid_buffer` in the analyzer datapath. It consumes the valid/ready/last sample stream, treats each `s_last`-terminated packet as one frame, and emits one result beat per frame: peak absolute value, sum of squares and sample count. The RMS divide/sqrt stage downstream consumes that result.

---
 rtl/peak_rms_pkg.sv | 29 ++
 rtl/sample_sq_stage.sv | 59 +++++
 rtl/frame_peak_rms.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/peak_rms_pkg.sv
// Shared types and default widths for the per-frame peak / energy accumulator.
package peak_rms_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int CNT_W_DEF    = 16;

    // Sum-of-squares width: a full-precision square per sample, plus headroom
    // for the largest count the frame counter can reach.
    function automatic int acc_w(input int sample_w, input int cnt_w);
        return 2 * sample_w + cnt_w;
    endfunction

    localparam int ACC_W_DEF = acc_w(SAMPLE_W_DEF, CNT_W_DEF);

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    // Result beat layout at the default widths.
    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] peak;
        logic [ACC_W_DEF-1:0]    sumsq;
        logic [CNT_W_DEF-1:0]    count;
        logic                    sat;
    } result_t;

endpackage

// File: rtl/sample_sq_stage.sv
// Stage 1: registers |x| and x^2 of an accepted sample with its last flag.
module sample_sq_stage
    import peak_rms_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [SAMPLE_W-1:0]   in_sample,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [SAMPLE_W-1:0]   out_abs,
    output logic [2*SAMPLE_W-1:0] out_sq,
    output logic                  out_last
);

    logic                  valid_q, valid_d;
    logic [SAMPLE_W-1:0]   abs_q, abs_d;
    logic [2*SAMPLE_W-1:0] sq_q, sq_d;
    logic                  last_q, last_d;
    logic [SAMPLE_W-1:0]   mag;

    // Magnitude as unsigned: negating the most negative value wraps to
    // 2^(SAMPLE_W-1), which is exactly its magnitude when read unsigned.
    always_comb begin
        mag     = in_sample[SAMPLE_W-1] ? SAMPLE_W'(~in_sample + 1'b1) : in_sample;
        valid_d = in_valid;
        abs_d   = abs_q;
        sq_d    = sq_q;
        last_d  = last_q;
        if (in_valid) begin
            abs_d  = mag;
            sq_d   = {{SAMPLE_W{1'b0}}, mag} * {{SAMPLE_W{1'b0}}, mag};
            last_d = in_last;
        end
    end

    // Stage register; payload only loads on a valid beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            abs_q   <= '0;
            sq_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            abs_q   <= abs_d;
            sq_q    <= sq_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_abs   = abs_q;
    assign out_sq    = sq_q;
    assign out_last  = last_q;

endmodule

// File: rtl/frame_peak_rms.sv
// Per-frame peak |x|, sum of squares and sample count, one result beat per
// s_last-terminated frame. Input stalls while a result is pending.
module frame_peak_rms
    import peak_rms_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int SAMPLE_W = SAMPLE_W_DEF,
    parameter  int CNT_W    = CNT_W_DEF,
    localparam int ACC_W    = 2 * SAMPLE_W + CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SAMPLE_W-1:0] m_peak,
    output logic [ACC_W-1:0]    m_sumsq,
    output logic [CNT_W-1:0]    m_count,
    output logic                m_sat
);

    typedef struct packed {
        logic [SAMPLE_W-1:0] peak;
        logic [ACC_W-1:0]    sumsq;
        logic [CNT_W-1:0]    count;
        logic                sat;
    } res_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

    state_t                state_q, state_d;
    logic [SAMPLE_W-1:0]   peak_q, peak_d;
    logic [ACC_W-1:0]      sumsq_q, sumsq_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sat_q, sat_d;
    res_t                  res_q, res_d;
    logic                  m_valid_q, m_valid_d;

    logic                  s1_valid;
    logic [SAMPLE_W-1:0]   s1_abs;
    logic [2*SAMPLE_W-1:0] s1_sq;
    logic                  s1_last;
    logic                  s_fire;

    // Bits above the sample field carry nothing for this block.
    generate
        if (DATA_W > SAMPLE_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^s_data[DATA_W-1:SAMPLE_W];
        end
    endgenerate

    assign s_ready = (state_q == ST_ACC) && rst_n;
    assign s_fire  = s_valid && s_ready;

    sample_sq_stage #(
        .SAMPLE_W (SAMPLE_W)
    ) u_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_fire),
        .in_sample (s_data[SAMPLE_W-1:0]),
        .in_last   (s_last),
        .out_valid (s1_valid),
        .out_abs   (s1_abs),
        .out_sq    (s1_sq),
        .out_last  (s1_last)
    );

    // Accumulate stage-1 samples, sequence the frame FSM and capture the result.
    always_comb begin
        state_d   = state_q;
        peak_d    = peak_q;
        sumsq_d   = sumsq_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        res_d     = res_q;
        m_valid_d = m_valid_q;

        if (s1_valid) begin
            if (s1_abs > peak_q) peak_d = s1_abs;
            // Once the counter is full, energy and count freeze; peak keeps tracking.
            if (cnt_q != CNT_MAX) begin
                sumsq_d = sumsq_q + ACC_W'(s1_sq);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_PRE) sat_d = 1'b1;
            end else begin
                sat_d = 1'b1;
            end
        end

        case (state_q)
            ST_ACC: begin
                if (s_fire && s_last) state_d = ST_FLUSH;
            end
            // Stage 2 absorbs the last sample this cycle.
            ST_FLUSH: begin
                state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (!m_valid_q) begin
                    res_d     = '{peak: peak_q, sumsq: sumsq_q, count: cnt_q, sat: sat_q};
                    m_valid_d = 1'b1;
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    res_d     = '0;
                    peak_d    = '0;
                    sumsq_d   = '0;
                    cnt_d     = '0;
                    sat_d     = 1'b0;
                    state_d   = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase

        // s1_last is implied by the FLUSH state; kept for observability.
        if (s1_valid && s1_last && state_q == ST_ACC) state_d = state_d;
    end

    // State, accumulators and result register; reset drops any pending frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_ACC;
            peak_q    <= '0;
            sumsq_q   <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            res_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            peak_q    <= peak_d;
            sumsq_q   <= sumsq_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            res_q     <= res_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_peak  = res_q.peak;
    assign m_sumsq = res_q.sumsq;
    assign m_count = res_q.count;
    assign m_sat   = res_q.sat;

endmodule
